divide: RTL and testbench
=========================

DIVIDE -- requirements
Module: divide

Interface
REQ-001 Parameter N_WIDTH, default 32, dividend and quotient width in bits.
REQ-002 Parameter D_WIDTH, default 16, divisor and remainder width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand strobe; operands are accepted when in_valid && in_ready at a rising edge.
REQ-006 in_N  input  N_WIDTH  signed dividend.
REQ-007 in_D  input  D_WIDTH  signed divisor.
REQ-008 in_ready  output  1  high only in IDLE.
REQ-009 out_valid  output  1  one-cycle pulse marking out_Q/out_R valid.
REQ-010 out_Q  output  N_WIDTH  signed quotient.
REQ-011 out_R  output  D_WIDTH  signed remainder.
REQ-012 out_div0  output  1  divide-by-zero flag; port exists only with DIVIDE_DIV0_EN.

Function
REQ-013 The block SHALL compute N/D, with the quotient truncated toward zero and the remainder taking the dividend's sign, so that Q*D+R == N and |R| < |D|.
REQ-014 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-015 IDLE->CALC on accept: latch |N| and |D|, the sign of N, and the sign of N xor the sign of D; clear the partial remainder.
REQ-016 CALC: perform one restoring shift/subtract step per cycle for exactly N_WIDTH cycles, using a counter that counts down from N_WIDTH-1; after the last step go to FIX.
REQ-017 FIX: negate the quotient and/or remainder per the latched signs; the result is registered into out_Q/out_R; go to DONE.
REQ-018 DONE: out_valid=1 for exactly one cycle, then return to IDLE.
REQ-019 Latency: if acceptance occurs at edge t0, out_valid SHALL be high in the cycle following edge t0+N_WIDTH+2; throughput is one operation per N_WIDTH+3 cycles.
REQ-020 in_valid while in_ready=0 SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-021 out_Q/out_R/out_div0 SHALL hold their last result until the next FIX updates them.
REQ-022 Overflow: -2^(N_WIDTH-1) / -1 SHALL yield Q=-2^(N_WIDTH-1) (wraps) and R=0, with no flag.
REQ-023 The internal partial remainder SHALL be D_WIDTH+1 bits to absorb the subtract borrow; |D| of -2^(D_WIDTH-1) SHALL be handled unsigned.

Reset
REQ-024 reset SHALL force IDLE, in_ready=1, out_valid=0, out_Q=0, out_R=0, out_div0=0, and counter=0.
REQ-025 reset asserted mid-operation SHALL abort the operation without producing an out_valid pulse; the first acceptance is possible on the edge after reset deasserts.

Configuration
REQ-026 Macro DIVIDE_DIV0_EN defined: if D==0 at accept, go IDLE->FIX directly (skipping CALC), then DONE with out_Q=all ones, out_R=0, out_div0=1, and out_valid after edge t0+2; out_div0=0 for every nonzero divisor.
REQ-027 DIVIDE_DIV0_EN undefined: no out_div0 port and no zero check; D==0 runs the full N_WIDTH+3-cycle sequence; out_Q/out_R are unspecified but out_valid timing is per REQ-019.

Structure
REQ-028 Package divide_pkg SHALL hold the FSM state typedef (IDLE/CALC/FIX/DONE) and the default width constants.
REQ-029 One combinational sub-module, divide_step, SHALL implement a single restoring iteration: inputs are the partial remainder, the next dividend bit and |D|; outputs are the new partial remainder and the quotient bit.

Verification
REQ-030 N=100, D=7, with in_valid held for 1 cycle -> Q=14, R=2, and out_valid exactly 34 cycles after the accept edge (N_WIDTH=32).
REQ-031 Sign cases -> -100/7: Q=-14, R=-2; 100/-7: Q=-14, R=2; -100/-7: Q=14, R=-2.
REQ-032 N=32'h80000000, D=-1 -> Q=32'h80000000, R=0; N=32'h7FFFFFFF, D=16'h8000 -> Q=-65535, R=32767.
REQ-033 in_valid held high continuously with changing operands -> only the operands at IDLE edges are used, and each out_valid is separated by 35 cycles.
REQ-034 reset pulsed at CALC cycle 10 -> no out_valid, outputs zero, and a new 100/7 completes correctly afterwards.
REQ-035 With DIVIDE_DIV0_EN, N=5, D=0 -> out_div0=1, Q=32'hFFFFFFFF, R=0, and out_valid 2 cycles after accept; the next 100/7 clears out_div0.

Source files
------------

// File: rtl/divide_pkg.sv
// divide_pkg
//   Shared definitions for the sequential signed divider:
//     - state_t          : controller states IDLE / CALC / FIX / DONE
//     - DEFAULT_N_WIDTH  : default dividend / quotient width
//     - DEFAULT_D_WIDTH  : default divisor / remainder width
package divide_pkg;

    localparam int DEFAULT_N_WIDTH = 32;
    localparam int DEFAULT_D_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/divide_step.sv
// divide_step
//   One combinational restoring-division iteration on unsigned magnitudes.
//   Ports:
//     rem_in  [D_WIDTH:0]   partial remainder before this step
//     n_bit                 next dividend bit shifted in (MSB first)
//     d_abs   [D_WIDTH-1:0] divisor magnitude (unsigned, may be 2^(D_WIDTH-1))
//     rem_out [D_WIDTH:0]   partial remainder after this step
//     q_bit                 quotient bit produced by this step
module divide_step
    import divide_pkg::*;
#(
    parameter int D_WIDTH = DEFAULT_D_WIDTH
) (
    input  logic [D_WIDTH:0]   rem_in,
    input  logic               n_bit,
    input  logic [D_WIDTH-1:0] d_abs,
    output logic [D_WIDTH:0]   rem_out,
    output logic               q_bit
);

    localparam int RW = D_WIDTH + 1;

    logic [D_WIDTH+1:0] shifted;
    logic [D_WIDTH+1:0] divisor_ext;

    // Shift the next dividend bit in and subtract the divisor only when it
    // fits; the extra top bit keeps the comparison free of wrap-around.
    always_comb begin
        shifted     = {rem_in, n_bit};
        divisor_ext = {2'b00, d_abs};
        q_bit       = (shifted >= divisor_ext);
        rem_out     = shifted[D_WIDTH:0];
        if (q_bit) begin
            rem_out = RW'(shifted - divisor_ext);
        end
    end

endmodule

// File: rtl/divide.sv
// divide
//   Multi-cycle signed divider: quotient truncated toward zero, remainder
//   carries the dividend's sign. One restoring step per CALC cycle.
//   Ports:
//     clk, reset            clock and synchronous active-high reset
//     in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//     in_N, in_D            signed dividend / divisor
//     out_valid             one-cycle pulse when out_Q / out_R are valid
//     out_Q, out_R          signed quotient / remainder (held until next FIX)
//     out_div0              divide-by-zero flag (only with DIVIDE_DIV0_EN)
//   Build option:
//     DIVIDE_DIV0_EN        adds out_div0 and a fast path for a zero divisor
module divide
    import divide_pkg::*;
#(
    parameter int N_WIDTH = DEFAULT_N_WIDTH,
    parameter int D_WIDTH = DEFAULT_D_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [N_WIDTH-1:0] in_N,
    input  logic [D_WIDTH-1:0] in_D,
    output logic               in_ready,
    output logic               out_valid,
    output logic [N_WIDTH-1:0] out_Q,
    output logic [D_WIDTH-1:0] out_R
`ifdef DIVIDE_DIV0_EN
    ,
    output logic               out_div0
`endif
);

    localparam int CNT_W = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   count;
    logic [N_WIDTH-1:0] n_shift;
    logic [D_WIDTH:0]   rem;
    logic [D_WIDTH-1:0] d_mag;
    logic               n_neg;
    logic               q_neg;
    logic               accept;
    logic               zero_div;
    logic [N_WIDTH-1:0] in_n_mag;
    logic [D_WIDTH-1:0] in_d_mag;
    logic [D_WIDTH:0]   step_rem;
    logic               step_q;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // Magnitudes are kept unsigned so the most negative value of either
    // operand (e.g. -2^(D_WIDTH-1)) still has a representable magnitude.
    assign in_n_mag = in_N[N_WIDTH-1] ? -in_N : in_N;
    assign in_d_mag = in_D[D_WIDTH-1] ? -in_D : in_D;

`ifdef DIVIDE_DIV0_EN
    logic div0_pending;
    assign zero_div = (in_D == '0);
`else
    assign zero_div = 1'b0;
`endif

    divide_step #(
        .D_WIDTH (D_WIDTH)
    ) u_step (
        .rem_in  (rem),
        .n_bit   (n_shift[N_WIDTH-1]),
        .d_abs   (d_mag),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a zero divisor (when checked) jumps straight to FIX.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = zero_div ? FIX : CALC;
                end
            end
            CALC: begin
                if (count == '0) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath. n_shift starts as |N| and, as bits are consumed from the top,
    // fills with quotient bits from the bottom, so it holds |Q| after CALC.
    // out_valid is registered from DONE, so the pulse appears in the cycle
    // after DONE while the controller is already back in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            n_shift   <= '0;
            rem       <= '0;
            d_mag     <= '0;
            n_neg     <= 1'b0;
            q_neg     <= 1'b0;
            out_valid <= 1'b0;
            out_Q     <= '0;
            out_R     <= '0;
`ifdef DIVIDE_DIV0_EN
            div0_pending <= 1'b0;
            out_div0     <= 1'b0;
`endif
        end else begin
            out_valid <= (state == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        n_shift <= in_n_mag;
                        d_mag   <= in_d_mag;
                        n_neg   <= in_N[N_WIDTH-1];
                        q_neg   <= in_N[N_WIDTH-1] ^ in_D[D_WIDTH-1];
                        rem     <= '0;
                        count   <= CNT_W'(N_WIDTH - 1);
`ifdef DIVIDE_DIV0_EN
                        div0_pending <= zero_div;
`endif
                    end
                end
                CALC: begin
                    n_shift <= {n_shift[N_WIDTH-2:0], step_q};
                    rem     <= step_rem;
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
`ifdef DIVIDE_DIV0_EN
                    if (div0_pending) begin
                        out_Q    <= '1;
                        out_R    <= '0;
                        out_div0 <= 1'b1;
                    end else begin
                        out_Q    <= q_neg ? -n_shift : n_shift;
                        out_R    <= n_neg ? -rem[D_WIDTH-1:0] : rem[D_WIDTH-1:0];
                        out_div0 <= 1'b0;
                    end
`else
                    out_Q <= q_neg ? -n_shift : n_shift;
                    out_R <= n_neg ? -rem[D_WIDTH-1:0] : rem[D_WIDTH-1:0];
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divide.sv
// tb_divide
//   Self-checking bench for divide (N_WIDTH=32, D_WIDTH=16): directed vector
//   table, randomized operands against a signed-arithmetic reference model,
//   back-to-back throughput, mid-operation reset and (with DIVIDE_DIV0_EN)
//   the divide-by-zero path.
module tb_divide;

    localparam int NW = 32;
    localparam int DW = 16;
    localparam int LAT = NW + 2;
    localparam int PERIOD = NW + 3;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [NW-1:0] in_N;
    logic [DW-1:0] in_D;
    logic          in_ready;
    logic          out_valid;
    logic [NW-1:0] out_Q;
    logic [DW-1:0] out_R;
`ifdef DIVIDE_DIV0_EN
    logic          out_div0;
`endif

    int test_count = 0;
    int fail_count = 0;

    typedef struct {
        logic [NW-1:0] n;
        logic [DW-1:0] d;
        logic [NW-1:0] q;
        logic [DW-1:0] r;
    } vec_t;

    vec_t vecs[8];

    divide #(
        .N_WIDTH (NW),
        .D_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_N      (in_N),
        .in_D      (in_D),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_Q     (out_Q),
        .out_R     (out_R)
`ifdef DIVIDE_DIV0_EN
        ,
        .out_div0  (out_div0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference: plain signed division, C-style truncation toward zero.
    function automatic void ref_div(input logic [NW-1:0] n, input logic [DW-1:0] d,
                                    output logic [NW-1:0] q, output logic [DW-1:0] r);
        longint sn, sd, sq, sr;
        sn = longint'($signed(n));
        sd = longint'($signed(d));
        sq = sn / sd;
        sr = sn % sd;
        q  = sq[NW-1:0];
        r  = sr[DW-1:0];
    endfunction

    // Offer one operation, wait for its out_valid (bounded) and report the
    // number of cycles from the accept edge, the results and whether
    // out_valid was still high one cycle later.
    task automatic applyStimulus(input logic [NW-1:0] n, input logic [DW-1:0] d,
                                 output int lat, output logic [NW-1:0] q,
                                 output logic [DW-1:0] r, output logic dz,
                                 output logic pulse_after);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_N     = n;
        in_D     = d;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        q  = out_Q;
        r  = out_R;
`ifdef DIVIDE_DIV0_EN
        dz = out_div0;
`else
        dz = 1'b0;
`endif
        @(negedge clk);
        pulse_after = out_valid;
    endtask

    logic [NW-1:0] got_q, exp_q;
    logic [DW-1:0] got_r, exp_r;
    logic          got_dz, got_after;
    int            got_lat;
    logic [NW-1:0] n_seq[PERIOD*3+5];
    logic [DW-1:0] d_seq[PERIOD*3+5];

    initial begin
        int pulse_errors;
        int pulses;
        int stray;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_N     = '0;
        in_D     = '0;

        vecs[0] = '{32'd100,        16'd7,      32'd14,         16'd2};
        vecs[1] = '{-32'sd100,      16'd7,      -32'sd14,       -16'sd2};
        vecs[2] = '{32'd100,        -16'sd7,    -32'sd14,       16'd2};
        vecs[3] = '{-32'sd100,      -16'sd7,    32'd14,         -16'sd2};
        vecs[4] = '{32'h8000_0000,  16'hFFFF,   32'h8000_0000,  16'd0};
        vecs[5] = '{32'h7FFF_FFFF,  16'h8000,   -32'sd65535,    16'd32767};
        vecs[6] = '{32'd0,          16'd5,      32'd0,          16'd0};
        vecs[7] = '{32'd5,          16'd3,      32'd1,          16'd2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_Q", 64'(out_Q), 64'd0);
        checkOutput("reset_out_R", 64'(out_R), 64'd0);
`ifdef DIVIDE_DIV0_EN
        checkOutput("reset_out_div0", 64'(out_div0), 64'd0);
`endif
        reset = 1'b0;

        // Directed vectors: values, latency and single-cycle pulse.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].n, vecs[i].d, got_lat, got_q, got_r, got_dz, got_after);
            checkOutput($sformatf("vec%0d_Q", i), 64'(got_q), 64'(vecs[i].q));
            checkOutput($sformatf("vec%0d_R", i), 64'(got_r), 64'(vecs[i].r));
            checkOutput($sformatf("vec%0d_latency", i), 64'(got_lat), 64'(LAT));
            checkOutput($sformatf("vec%0d_pulse_width", i), 64'(got_after), 64'd0);
`ifdef DIVIDE_DIV0_EN
            checkOutput($sformatf("vec%0d_div0", i), 64'(got_dz), 64'd0);
`endif
        end

        // Results hold while idle.
        repeat (5) @(negedge clk);
        checkOutput("hold_Q", 64'(out_Q), 64'(vecs[7].q));
        checkOutput("hold_R", 64'(out_R), 64'(vecs[7].r));

        // Randomized operands against the reference model.
        for (int i = 0; i < 16; i++) begin
            logic [NW-1:0] rn;
            logic [DW-1:0] rd;
            rn = NW'($urandom);
            rd = (i % 2 == 0) ? DW'($urandom_range(1, 40)) : DW'($urandom);
            if (i % 4 == 3) rd = -rd;
            if (rd == '0) rd = DW'(16'd9);
            ref_div(rn, rd, exp_q, exp_r);
            applyStimulus(rn, rd, got_lat, got_q, got_r, got_dz, got_after);
            checkOutput($sformatf("rand%0d_Q", i), 64'(got_q), 64'(exp_q));
            checkOutput($sformatf("rand%0d_R", i), 64'(got_r), 64'(exp_r));
        end

        // in_valid held high with operands changing every cycle: only the
        // operands present at accept edges (every PERIOD cycles) count.
        for (int j = 0; j < PERIOD * 3 + 5; j++) begin
            n_seq[j] = NW'($urandom);
            d_seq[j] = DW'($urandom_range(1, 1000));
            if (j % 2 == 1) d_seq[j] = -d_seq[j];
        end
        pulse_errors = 0;
        pulses       = 0;
        for (int j = 0; j < PERIOD * 3 + 1; j++) begin
            @(negedge clk);
            if (out_valid) pulses++;
            if (out_valid !== (j > 0 && j % PERIOD == 0)) pulse_errors++;
            if (j > 0 && j % PERIOD == 0) begin
                ref_div(n_seq[j-PERIOD], d_seq[j-PERIOD], exp_q, exp_r);
                checkOutput($sformatf("stream%0d_Q", j / PERIOD), 64'(out_Q), 64'(exp_q));
                checkOutput($sformatf("stream%0d_R", j / PERIOD), 64'(out_R), 64'(exp_r));
            end
            in_N     = n_seq[j];
            in_D     = d_seq[j];
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("stream_pulse_errors", 64'(pulse_errors), 64'd0);
        checkOutput("stream_pulse_count", 64'(pulses), 64'd3);
        repeat (PERIOD + 2) @(negedge clk);

        // Reset during CALC cycle 10 aborts the operation.
        in_N     = 32'd100;
        in_D     = 16'd7;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 50; k++) begin
            if (out_valid) stray++;
            @(negedge clk);
        end
        checkOutput("abort_no_valid", 64'(stray), 64'd0);
        checkOutput("abort_out_Q", 64'(out_Q), 64'd0);
        checkOutput("abort_out_R", 64'(out_R), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        applyStimulus(32'd100, 16'd7, got_lat, got_q, got_r, got_dz, got_after);
        checkOutput("after_abort_Q", 64'(got_q), 64'd14);
        checkOutput("after_abort_R", 64'(got_r), 64'd2);
        checkOutput("after_abort_latency", 64'(got_lat), 64'(LAT));

`ifdef DIVIDE_DIV0_EN
        // Zero divisor: fast path and flag, then cleared by a normal divide.
        applyStimulus(32'd5, 16'd0, got_lat, got_q, got_r, got_dz, got_after);
        checkOutput("div0_flag", 64'(got_dz), 64'd1);
        checkOutput("div0_Q", 64'(got_q), 64'hFFFF_FFFF);
        checkOutput("div0_R", 64'(got_r), 64'd0);
        checkOutput("div0_latency", 64'(got_lat), 64'd2);
        applyStimulus(32'd100, 16'd7, got_lat, got_q, got_r, got_dz, got_after);
        checkOutput("div0_clear_flag", 64'(got_dz), 64'd0);
        checkOutput("div0_clear_Q", 64'(got_q), 64'd14);
        checkOutput("div0_clear_R", 64'(got_r), 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
